pe_array_sched: RTL and testbench
=================================

Name: pe_array_sched

Overview:
- Parametrised successor of the single-pass PE-array controller. Sequences a PE_COUNT-wide processing-element array over FILTG_CNT filter groups × IFG_CNT ifmap groups.
- Per pass it generates filter-load and ifmap-load windows, a one-hot PE write select, a broadcast PE start, and psum mode (fresh vs accumulate).
- Collects per-PE done pulses and signals completion of the whole layer.
- Sits between the top-level start and the datapath's address generators, SRAM address mux and PE array.

Parameters:
- PE_COUNT, 4: number of PEs; width of the one-hot and done vectors (≥1).
- IFG_CNT, 4: ifmap groups per filter group (≥1).
- FILTG_CNT, 2: filter groups per layer (≥1).
- FILT_LOAD_CYCLES, 8: cycles the filter load window stays open per filter group (≥1).
- IF_LOAD_CYCLES, 6: ifmap write cycles per PE per ifmap group (≥1).
- Localparams: IFG_W = max(1,$clog2(IFG_CNT)); FG_W = max(1,$clog2(FILTG_CNT)); LC_W sized for the larger load count.

Ports:
- clk, in, 1: rising-edge clock.
- rst, in, 1: asynchronous, active-low reset.
- start, in, 1: begin layer; sampled only in IDLE.
- abort, in, 1: synchronous abort back to IDLE.
- pe_done, in, PE_COUNT: per-PE one-cycle done pulses.
- busy, out, 1: high in every state except IDLE.
- sel_addr, out, 1: SRAM address source; 1 = filter generator, 0 = ifmap generator.
- filt_wen, out, 1: filter scratch write enable.
- ifwen, out, 1: ifmap buffer write enable.
- pe_sel, out, PE_COUNT: one-hot target PE for ifmap writes.
- pe_start, out, 1: one-cycle broadcast start to all PEs.
- mode, out, 1: 0 = fresh psum, 1 = accumulate.
- ifg_idx, out, IFG_W: current ifmap group.
- filtg_idx, out, FG_W: current filter group.
- done_all, out, 1: one-cycle pulse at layer completion.

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0, except pe_sel = 1 (PE0); all counters and done_mask cleared.
- All outputs are registered, or decoded from registered state/counters only; no combinational path from inputs to outputs.
- States: IDLE, LOAD_FILT, LOAD_IF, START, WAIT, NEXT, DONE.
- IDLE: start=1 → LOAD_FILT next cycle; ifg_idx, filtg_idx, load counter and pe_sel reset to 0 / PE0.
- LOAD_FILT:
  - sel_addr=1, filt_wen=1 for exactly FILT_LOAD_CYCLES cycles (counter 0..N-1).
  - Then → LOAD_IF with counter cleared.
- LOAD_IF:
  - sel_addr=0, ifwen=1. Each PE receives IF_LOAD_CYCLES consecutive write cycles, PE0 first.
  - pe_sel rotates left one position when the counter wraps.
  - After the last PE's last cycle: pe_sel returns to PE0, → START.
  - Total length: PE_COUNT×IF_LOAD_CYCLES cycles.
- START: pe_start=1 for one cycle; done_mask cleared → WAIT.
- WAIT:
  - done_mask |= pe_done each cycle.
  - Leave when (done_mask | pe_done) is all ones → NEXT. Simultaneous and staggered done pulses are both accepted.
  - pe_done bits outside WAIT are ignored.
  - A PE pulsing done twice has no extra effect.
- NEXT (1 cycle):
  - If ifg_idx < IFG_CNT-1: ifg_idx++ → LOAD_IF. Filters are not reloaded.
  - Else if filtg_idx < FILTG_CNT-1: filtg_idx++, ifg_idx=0 → LOAD_FILT.
  - Else → DONE.
- DONE: done_all=1 for one cycle → IDLE; indices held until next start.
- mode = (ifg_idx != 0), valid from LOAD_IF through WAIT. The first ifmap group of every filter group starts fresh.
- start while busy: ignored, no restart.
- abort=1 in any non-IDLE state:
  - → IDLE next cycle; counters cleared, no done_all.
  - abort has priority over every transition, including DONE.
  - abort in IDLE: no effect, and has priority over a simultaneous start.
- Degenerate case PE_COUNT=1: pe_sel stays 1.
- Degenerate case IFG_CNT=1: NEXT always proceeds to the filter-group test.
- Pass latency, excluding WAIT: FILT_LOAD_CYCLES (first group only) + PE_COUNT×IF_LOAD_CYCLES + 1 (START) + 1 (NEXT).
- Counters are saturation-free and sized by the localparams. The final index values never exceed CNT-1.

Test Plan:
- PE_COUNT=2, IFG_CNT=2, FILTG_CNT=1, FILT_LOAD=2, IF_LOAD=3, PEs return done 4 cycles after pe_start:
  - filt_wen high 2 cycles; ifwen high 6 cycles with pe_sel 01,01,01,10,10,10.
  - Two pe_start pulses; mode 0 then 1.
  - done_all exactly once, then busy=0.
- Staggered done (PE0 at +2, PE1 at +7) vs simultaneous (both at +3): WAIT exits on the cycle of the last pulse in both cases; an extra PE0 pulse in LOAD_IF is ignored.
- FILTG_CNT=2, IFG_CNT=2: filtg_idx 0→1, and LOAD_FILT is re-entered once. mode sequence 0,1,0,1; done_all after the fourth WAIT.
- start pulsed during LOAD_IF and WAIT: no restart, indices unaffected. start in IDLE after done_all: a new layer begins from index 0.
- abort in WAIT, and separately rst=0 in LOAD_IF with clock stopped: both reach IDLE, all outputs 0 (pe_sel=1), no done_all. A subsequent start runs a full layer correctly.
- PE_COUNT=1, IFG_CNT=1, FILTG_CNT=1: pe_sel constantly 1; exact sequence LOAD_FILT, LOAD_IF, START, WAIT, NEXT, DONE; mode stays 0.

Source files
------------

// File: rtl/pe_array_sched.sv
// pe_array_sched: sequences a PE array over FILTG_CNT filter groups x IFG_CNT ifmap groups.
// Each pass opens a filter-load window (first ifmap group of a filter group only), writes
// IF_LOAD_CYCLES ifmap words into each PE in turn, broadcasts a start, then collects the
// per-PE done pulses before stepping to the next group. Outputs decode registered state only.
module pe_array_sched #(
    parameter int unsigned PE_COUNT         = 4,
    parameter int unsigned IFG_CNT          = 4,
    parameter int unsigned FILTG_CNT        = 2,
    parameter int unsigned FILT_LOAD_CYCLES = 8,
    parameter int unsigned IF_LOAD_CYCLES   = 6,
    localparam int unsigned IFG_W  = (IFG_CNT > 1) ? $clog2(IFG_CNT) : 1,
    localparam int unsigned FG_W   = (FILTG_CNT > 1) ? $clog2(FILTG_CNT) : 1,
    localparam int unsigned LC_MAX = (FILT_LOAD_CYCLES > IF_LOAD_CYCLES) ?
                                     FILT_LOAD_CYCLES : IF_LOAD_CYCLES,
    localparam int unsigned LC_W   = (LC_MAX > 1) ? $clog2(LC_MAX) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [PE_COUNT-1:0] pe_done,
    output logic                busy,
    output logic                sel_addr,
    output logic                filt_wen,
    output logic                ifwen,
    output logic [PE_COUNT-1:0] pe_sel,
    output logic                pe_start,
    output logic                mode,
    output logic [IFG_W-1:0]    ifg_idx,
    output logic [FG_W-1:0]     filtg_idx,
    output logic                done_all
);

    typedef enum logic [2:0] {
        StIdle,
        StLoadFilt,
        StLoadIf,
        StStart,
        StWait,
        StNext,
        StDone
    } state_e;

    state_e              state_q;
    logic [LC_W-1:0]     lc_q;
    logic [PE_COUNT-1:0] pe_sel_q;
    logic [PE_COUNT-1:0] mask_q;
    logic [IFG_W-1:0]    ifg_q;
    logic [FG_W-1:0]     fg_q;
    logic [PE_COUNT-1:0] mask_next;

    // Done pulses seen so far in this pass, including the current cycle.
    always_comb begin
        mask_next = mask_q | pe_done;
    end

    // Sequencer: state, load counter, PE select rotation, group indices and done collection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            lc_q     <= '0;
            pe_sel_q <= PE_COUNT'(1);
            mask_q   <= '0;
            ifg_q    <= '0;
            fg_q     <= '0;
        end else if (abort && (state_q != StIdle)) begin
            // Abort wins over every transition, DONE included, so no done_all can leak out.
            state_q  <= StIdle;
            lc_q     <= '0;
            pe_sel_q <= PE_COUNT'(1);
            mask_q   <= '0;
            ifg_q    <= '0;
            fg_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // abort in IDLE has no effect of its own but still masks start
                    if (start && !abort) begin
                        state_q  <= StLoadFilt;
                        lc_q     <= '0;
                        pe_sel_q <= PE_COUNT'(1);
                        ifg_q    <= '0;
                        fg_q     <= '0;
                    end
                end
                StLoadFilt: begin
                    if (lc_q == LC_W'(FILT_LOAD_CYCLES - 1)) begin
                        lc_q    <= '0;
                        state_q <= StLoadIf;
                    end else begin
                        lc_q <= lc_q + LC_W'(1);
                    end
                end
                StLoadIf: begin
                    if (lc_q == LC_W'(IF_LOAD_CYCLES - 1)) begin
                        lc_q <= '0;
                        if (pe_sel_q[PE_COUNT-1]) begin
                            pe_sel_q <= PE_COUNT'(1);
                            state_q  <= StStart;
                        end else begin
                            // MSB is clear here, so a plain shift is the left rotation
                            pe_sel_q <= pe_sel_q << 1;
                        end
                    end else begin
                        lc_q <= lc_q + LC_W'(1);
                    end
                end
                StStart: begin
                    mask_q  <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    mask_q <= mask_next;
                    if (&mask_next) begin
                        state_q <= StNext;
                    end
                end
                StNext: begin
                    if (ifg_q != IFG_W'(IFG_CNT - 1)) begin
                        ifg_q   <= ifg_q + IFG_W'(1);
                        state_q <= StLoadIf;
                    end else if (fg_q != FG_W'(FILTG_CNT - 1)) begin
                        fg_q    <= fg_q + FG_W'(1);
                        ifg_q   <= '0;
                        state_q <= StLoadFilt;
                    end else begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Output decode from registered state and counters only.
    always_comb begin
        busy      = (state_q != StIdle);
        sel_addr  = (state_q == StLoadFilt);
        filt_wen  = (state_q == StLoadFilt);
        ifwen     = (state_q == StLoadIf);
        pe_start  = (state_q == StStart);
        done_all  = (state_q == StDone);
        // first ifmap group of every filter group writes fresh psums
        mode      = (ifg_q != '0);
        pe_sel    = pe_sel_q;
        ifg_idx   = ifg_q;
        filtg_idx = fg_q;
    end

endmodule

// File: tb/tb_pe_array_sched.sv
// Bench for pe_array_sched: two instances (2 PE / 2 ifmap / 2 filter groups, and the
// fully degenerate 1/1/1 case). Expected per-cycle output vectors are queued by the
// stimulus; a monitor pops one per busy cycle and compares.
module tb_pe_array_sched;

    logic clk    = 1'b0;
    logic clk_en = 1'b1;
    logic rst    = 1'b1;

    always #5 clk = clk_en ? ~clk : 1'b0;

    // Instance A: PE_COUNT=2, IFG_CNT=2, FILTG_CNT=2, FILT_LOAD=2, IF_LOAD=3
    logic       start_a = 1'b0;
    logic       abort_a = 1'b0;
    logic [1:0] pe_done_a = '0;
    logic       busy_a, sel_addr_a, filt_wen_a, ifwen_a, pe_start_a, mode_a, done_a;
    logic [1:0] pe_sel_a;
    logic       ifg_a, fg_a;

    pe_array_sched #(
        .PE_COUNT(2), .IFG_CNT(2), .FILTG_CNT(2), .FILT_LOAD_CYCLES(2), .IF_LOAD_CYCLES(3)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .pe_done(pe_done_a),
        .busy(busy_a), .sel_addr(sel_addr_a), .filt_wen(filt_wen_a), .ifwen(ifwen_a),
        .pe_sel(pe_sel_a), .pe_start(pe_start_a), .mode(mode_a), .ifg_idx(ifg_a),
        .filtg_idx(fg_a), .done_all(done_a)
    );

    // Instance B: all counts 1, FILT_LOAD=2, IF_LOAD=3
    logic       start_b = 1'b0;
    logic       abort_b = 1'b0;
    logic [0:0] pe_done_b = '0;
    logic       busy_b, sel_addr_b, filt_wen_b, ifwen_b, pe_start_b, mode_b, done_b;
    logic [0:0] pe_sel_b;
    logic       ifg_b, fg_b;

    pe_array_sched #(
        .PE_COUNT(1), .IFG_CNT(1), .FILTG_CNT(1), .FILT_LOAD_CYCLES(2), .IF_LOAD_CYCLES(3)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .pe_done(pe_done_b),
        .busy(busy_b), .sel_addr(sel_addr_b), .filt_wen(filt_wen_b), .ifwen(ifwen_b),
        .pe_sel(pe_sel_b), .pe_start(pe_start_b), .mode(mode_b), .ifg_idx(ifg_b),
        .filtg_idx(fg_b), .done_all(done_b)
    );

    // {busy, sel_addr, filt_wen, ifwen, pe_sel[1:0], pe_start, mode, ifg, fg, done_all}
    logic [10:0] va, vb;
    assign va = {busy_a, sel_addr_a, filt_wen_a, ifwen_a, pe_sel_a, pe_start_a, mode_a,
                 ifg_a, fg_a, done_a};
    assign vb = {busy_b, sel_addr_b, filt_wen_b, ifwen_b, 1'b0, pe_sel_b, pe_start_b, mode_b,
                 ifg_b, fg_b, done_b};

    int errors = 0;
    int checks = 0;
    logic [10:0] qa[$];
    logic [10:0] qb[$];
    logic [10:0] exp_a, exp_b;

    // PE response model: done pulse d cycles after the pe_start cycle (99 = never)
    int dly_a0 = 4, dly_a1 = 4, dly_a2 = 99, dly_b = 2;
    int since_a = -1, since_b = -1;
    bit stray_en = 1'b0, stray_done = 1'b0;

    always @(negedge clk) begin
        if (pe_start_a) since_a = 0;
        else if (since_a >= 0 && since_a < 50) since_a++;
        pe_done_a = '0;
        if (since_a == dly_a0 || since_a == dly_a2) pe_done_a[0] = 1'b1;
        if (since_a == dly_a1) pe_done_a[1] = 1'b1;
        if (stray_en && !stray_done && ifwen_a) begin
            pe_done_a[0] = 1'b1;
            stray_done   = 1'b1;
        end
        if (pe_start_b) since_b = 0;
        else if (since_b >= 0 && since_b < 50) since_b++;
        pe_done_b = '0;
        if (since_b == dly_b) pe_done_b[0] = 1'b1;
    end

    // Monitor: every busy cycle must match the next queued expectation.
    always @(negedge clk) begin
        if (busy_a) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL a_trace: unexpected busy cycle, got %b required idle", va);
            end else begin
                exp_a = qa.pop_front();
                if (va !== exp_a) begin
                    errors++;
                    $display("FAIL a_trace: got %b required %b", va, exp_a);
                end
            end
        end
        if (busy_b) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL b_trace: unexpected busy cycle, got %b required idle", vb);
            end else begin
                exp_b = qb.pop_front();
                if (vb !== exp_b) begin
                    errors++;
                    $display("FAIL b_trace: got %b required %b", vb, exp_b);
                end
            end
        end
    end

    function automatic logic [10:0] pk(input logic b, input logic sa, input logic fw,
                                       input logic iw, input logic [1:0] ps, input logic st,
                                       input logic md, input logic ig, input logic fg,
                                       input logic da);
        return {b, sa, fw, iw, ps, st, md, ig, fg, da};
    endfunction

    task automatic add_a(input logic [10:0] v, inout int n, input int lim);
        if (lim < 0 || n < lim) qa.push_back(v);
        n++;
    endtask

    // Expected trace for a full A layer with WAIT lasting wl cycles, truncated to lim entries.
    task automatic push_a(input int wl, input int lim);
        int n = 0;
        for (int fg = 0; fg < 2; fg++) begin
            for (int c = 0; c < 2; c++)
                add_a(pk(1, 1, 1, 0, 2'b01, 0, 0, 0, 1'(fg), 0), n, lim);
            for (int ig = 0; ig < 2; ig++) begin
                for (int p = 0; p < 2; p++)
                    for (int c = 0; c < 3; c++)
                        add_a(pk(1, 0, 0, 1, 2'(1 << p), 0, ig != 0, 1'(ig), 1'(fg), 0),
                              n, lim);
                add_a(pk(1, 0, 0, 0, 2'b01, 1, ig != 0, 1'(ig), 1'(fg), 0), n, lim);
                for (int w = 0; w < wl; w++)
                    add_a(pk(1, 0, 0, 0, 2'b01, 0, ig != 0, 1'(ig), 1'(fg), 0), n, lim);
                add_a(pk(1, 0, 0, 0, 2'b01, 0, ig != 0, 1'(ig), 1'(fg), 0), n, lim);
            end
        end
        add_a(pk(1, 0, 0, 0, 2'b01, 0, 1, 1, 1, 1), n, lim);
    endtask

    task automatic push_b(input int wl);
        for (int c = 0; c < 2; c++) qb.push_back(pk(1, 1, 1, 0, 2'b01, 0, 0, 0, 0, 0));
        for (int c = 0; c < 3; c++) qb.push_back(pk(1, 0, 0, 1, 2'b01, 0, 0, 0, 0, 0));
        qb.push_back(pk(1, 0, 0, 0, 2'b01, 1, 0, 0, 0, 0));
        for (int w = 0; w < wl; w++) qb.push_back(pk(1, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0));
        qb.push_back(pk(1, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0));
        qb.push_back(pk(1, 0, 0, 0, 2'b01, 0, 0, 0, 0, 1));
    endtask

    // Leaves the caller at the negedge of the first busy cycle.
    task automatic go_a();
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
    endtask

    task automatic go_b();
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
    endtask

    task automatic drain(input int bound);
        int k = 0;
        while ((qa.size() != 0 || qb.size() != 0) && k < bound) begin
            @(negedge clk);
            #1;
            k++;
        end
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d cycles outstanding required 0/0",
                     qa.size(), qb.size());
            qa.delete();
            qb.delete();
        end
    endtask

    task automatic check_vec(input string name, input logic [10:0] got, input logic [10:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, got, req);
        end
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_vec("reset_a", va, pk(0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0));
        check_vec("reset_b", vb, pk(0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0));
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Full layer, both PEs done 4 cycles after start
        dly_a0 = 4; dly_a1 = 4; dly_a2 = 99;
        push_a(4, -1);
        go_a();
        drain(200);
        @(negedge clk);
        check_vec("idle_after_layer1", va, pk(0, 0, 0, 0, 2'b01, 0, 1, 1, 1, 0));

        // Restart straight from IDLE: indices must restart at 0; simultaneous done at +3
        dly_a0 = 3; dly_a1 = 3;
        push_a(3, -1);
        go_a();
        drain(200);
        @(negedge clk);
        check_vec("idle_after_layer2", va, pk(0, 0, 0, 0, 2'b01, 0, 1, 1, 1, 0));

        // Staggered done (+2, +7), PE0 pulses twice, stray PE0 pulse in LOAD_IF,
        // start pulsed during LOAD_IF and WAIT
        dly_a0 = 2; dly_a1 = 7; dly_a2 = 4;
        stray_done = 1'b0; stray_en = 1'b1;
        push_a(7, -1);
        go_a();
        repeat (4) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        repeat (5) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        drain(200);
        stray_en = 1'b0; dly_a2 = 99;
        @(negedge clk);
        check_vec("idle_after_layer3", va, pk(0, 0, 0, 0, 2'b01, 0, 1, 1, 1, 0));

        // Abort in the second WAIT cycle of the first pass (cycle 10)
        dly_a0 = 4; dly_a1 = 4;
        push_a(4, 11);
        go_a();
        repeat (10) @(negedge clk);
        abort_a = 1'b1;
        @(negedge clk) abort_a = 1'b0;
        #1;
        check_vec("idle_after_abort", va, pk(0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0));
        drain(5);
        repeat (8) @(negedge clk);
        check_vec("idle_after_abort_late", va, pk(0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0));

        // Full layer after abort
        dly_a0 = 3; dly_a1 = 3;
        push_a(3, -1);
        go_a();
        drain(200);
        @(negedge clk);
        check_vec("idle_after_layer4", va, pk(0, 0, 0, 0, 2'b01, 0, 1, 1, 1, 0));

        // Asynchronous reset in LOAD_IF (cycle 5) with the clock stopped
        push_a(3, 6);
        go_a();
        repeat (5) @(negedge clk);
        #1 clk_en = 1'b0;
        #20 rst = 1'b0;
        #1;
        check_vec("async_reset_a", va, pk(0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0));
        #20 rst = 1'b1;
        #3 clk_en = 1'b1;
        drain(5);
        repeat (2) @(negedge clk);
        check_vec("idle_after_reset", va, pk(0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0));

        // Full layer after reset
        push_a(3, -1);
        go_a();
        drain(200);

        // Degenerate instance
        dly_b = 2;
        push_b(2);
        go_b();
        drain(100);
        @(negedge clk);
        check_vec("idle_b", vb, pk(0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
